instruction_fetch_unit: RTL and testbench

Stage-side responder to the pipeline control unit. Accepts the control unit's `startInstructionFetch` and `programCounterWrite` strobes, performs an instruction-memory read over a request/acknowledge handshake, and returns `instructionFetched` and `programCounterUpdated` completion pulses. It owns the architectural program counter and sits between the control unit and instruction memory.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/fetch_watchdog.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// the NOP substituted on a watchdog timeout, and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2,
        HALTED  = 2'd3
    } fetch_state_e;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: request/acknowledge handshake with address and data.
// The fetch unit is the master; the memory model or controller is the slave.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  memReadRequest;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memReadAck;
    logic [DATA_WIDTH-1:0] memReadData;

    modport master (
        output memReadRequest,
        output memAddress,
        input  memReadAck,
        input  memReadData
    );

    modport slave (
        input  memReadRequest,
        input  memAddress,
        output memReadAck,
        output memReadData
    );
endinterface

// File: rtl/fetch_watchdog.sv
// Counts cycles spent waiting for a memory acknowledge; expire is high during the
// TIMEOUT_CYCLES-th waiting cycle. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = run && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage responder: owns the PC, runs one instruction-memory read per start strobe
// and returns completion pulses. Optional memory-ack watchdog: define FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC       = '0,
    parameter int unsigned             TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startInstructionFetch,
    input  logic                  programCounterWrite,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    input  logic                  haltExecution,
    instruction_fetch_unit_if.master mem,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instructionFetched,
    output logic [ADDR_WIDTH-1:0] programCounter,
    output logic                  programCounterUpdated,
    output logic                  busy,
    output logic                  fetchError
);

    fetch_state_e          state_q,   state_d;
    logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] instr_q,   instr_d;
    logic                  req_q,     req_d;
    logic                  fetched_q, fetched_d;
    logic                  pc_upd_q,  pc_upd_d;
    logic                  busy_q,    busy_d;
    logic                  err_q,     err_d;
    logic                  start_accept;
    logic                  wd_expire;

    assign start_accept = (state_q == IDLE) && !haltExecution && startInstructionFetch;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_accept),
        .run    (state_q == REQUEST),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        fetched_d = 1'b0;
        pc_upd_d  = 1'b0;
        err_d     = 1'b0;

        // PC update is independent of the fetch; the in-flight address stays in addr_q
        if (programCounterWrite && (state_q != HALTED)) begin
            pc_d     = branchTaken ? branchTarget : pc_q + ADDR_WIDTH'(PC_INCREMENT);
            pc_upd_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (haltExecution) begin
                    state_d = HALTED;
                end else if (startInstructionFetch) begin
                    addr_d  = pc_q;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                // A same-cycle ack beats the watchdog
                if (mem.memReadAck) begin
                    instr_d   = mem.memReadData;
                    fetched_d = 1'b1;
                    state_d   = DONE;
                end else if (wd_expire) begin
                    instr_d   = DATA_WIDTH'(NOP_INSTR);
                    fetched_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = haltExecution ? HALTED : IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d  = (state_d == REQUEST);
        busy_d = (state_d == REQUEST) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            instr_q   <= '0;
            req_q     <= 1'b0;
            fetched_q <= 1'b0;
            pc_upd_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            fetched_q <= fetched_d;
            pc_upd_q  <= pc_upd_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign mem.memReadRequest    = req_q;
    assign mem.memAddress        = addr_q;
    assign instruction           = instr_q;
    assign instructionFetched    = fetched_q;
    assign programCounter        = pc_q;
    assign programCounterUpdated = pc_upd_q;
    assign busy                  = busy_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetchError = err_q;
`else
    assign fetchError = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed cases with literal
// expectations, then randomized traffic checked every cycle against a reference model.
module tb_instruction_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_start = 1'b0;
    logic          in_pcw = 1'b0;
    logic          in_bt = 1'b0;
    logic [AW-1:0] in_tgt = '0;
    logic          in_halt = 1'b0;
    logic          in_ack = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic [DW-1:0] instruction;
    logic          instructionFetched;
    logic [AW-1:0] programCounter;
    logic          programCounterUpdated;
    logic          busy;
    logic          fetchError;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    assign mem_if.memReadAck  = in_ack;
    assign mem_if.memReadData = in_data;

    instruction_fetch_unit #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .RESET_PC       ('0),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .startInstructionFetch (in_start),
        .programCounterWrite   (in_pcw),
        .branchTaken           (in_bt),
        .branchTarget          (in_tgt),
        .haltExecution         (in_halt),
        .mem                   (mem_if.master),
        .instruction           (instruction),
        .instructionFetched    (instructionFetched),
        .programCounter        (programCounter),
        .programCounterUpdated (programCounterUpdated),
        .busy                  (busy),
        .fetchError            (fetchError)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch is either waiting on memory, just completed, or absent;
    // a halt latches permanently once no fetch is outstanding.
    bit          m_halted;
    bit          m_waiting;
    bit          m_just_done;
    int          m_waited;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_instr;
    bit          m_fetched;
    bit          m_upd;
    bit          m_err;

    task automatic model_step();
        logic [AW-1:0] next_pc;
        if (reset) begin
            m_halted = 0; m_waiting = 0; m_just_done = 0; m_waited = 0;
            m_pc = '0; m_addr = '0; m_instr = '0;
            m_fetched = 0; m_upd = 0; m_err = 0;
            return;
        end
        m_fetched = 0; m_upd = 0; m_err = 0;
        next_pc = m_pc;
        if (in_pcw && !m_halted) begin
            next_pc = in_bt ? in_tgt : AW'(m_pc + 4);
            m_upd = 1;
        end
        if (m_just_done) begin
            m_just_done = 0;
            if (in_halt) m_halted = 1;
        end else if (m_waiting) begin
            if (in_ack) begin
                m_instr = in_data; m_waiting = 0; m_just_done = 1; m_fetched = 1;
            end else begin
                m_waited++;
`ifdef FETCH_TIMEOUT_EN
                if (m_waited == TO) begin
                    m_instr = 32'h13; m_waiting = 0; m_just_done = 1;
                    m_fetched = 1; m_err = 1;
                end
`endif
            end
        end else if (!m_halted) begin
            if (in_halt) m_halted = 1;
            else if (in_start) begin
                m_addr = m_pc; m_waiting = 1; m_waited = 0;
            end
        end
        m_pc = next_pc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        check_en = 1'b1;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_req",     32'(mem_if.memReadRequest), 32'(m_waiting));
            chk("cyc_addr",    mem_if.memAddress,          m_addr);
            chk("cyc_instr",   instruction,                m_instr);
            chk("cyc_fetched", 32'(instructionFetched),    32'(m_fetched));
            chk("cyc_pc",      programCounter,             m_pc);
            chk("cyc_upd",     32'(programCounterUpdated), 32'(m_upd));
            chk("cyc_busy",    32'(busy),                  32'(m_waiting || m_just_done));
            chk("cyc_err",     32'(fetchError),            32'(m_err));
        end
    end

    bit halt_lvl;

    initial begin
        // Reset state
        reset = 1; tick(); tick(); reset = 0;
        tick();
        chk("rst_pc", programCounter, 32'h0);
        chk("rst_req", 32'(mem_if.memReadRequest), 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Fetch with ack in the first request cycle
        in_start = 1; tick(); in_start = 0;
        chk("f1_req", 32'(mem_if.memReadRequest), 32'h1);
        chk("f1_addr", mem_if.memAddress, 32'h0);
        chk("f1_busy", 32'(busy), 32'h1);
        in_ack = 1; in_data = 32'hDEADBEEF; tick(); in_ack = 0;
        chk("f1_instr", instruction, 32'hDEADBEEF);
        chk("f1_fetched", 32'(instructionFetched), 32'h1);
        tick();
        chk("f1_pulse_end", 32'(instructionFetched), 32'h0);
        chk("f1_idle_busy", 32'(busy), 32'h0);

        // PC updates, including wrap-around
        in_pcw = 1; in_bt = 1; in_tgt = 32'h10; tick();
        chk("pc_set10", programCounter, 32'h10);
        in_bt = 0; tick(); in_pcw = 0;
        chk("pc_inc14", programCounter, 32'h14);
        chk("pc_upd", 32'(programCounterUpdated), 32'h1);
        tick();
        chk("pc_upd_end", 32'(programCounterUpdated), 32'h0);
        in_pcw = 1; in_bt = 1; in_tgt = 32'h200; tick();
        chk("pc_branch", programCounter, 32'h200);
        in_tgt = 32'hFFFF_FFFC; tick();
        in_bt = 0; tick(); in_pcw = 0;
        chk("pc_wrap", programCounter, 32'h0);

        // Start and PC write in the same IDLE cycle
        in_pcw = 1; in_bt = 1; in_tgt = 32'h40; tick();
        in_bt = 0; in_start = 1; tick(); in_start = 0; in_pcw = 0;
        chk("sp_addr", mem_if.memAddress, 32'h40);
        chk("sp_pc", programCounter, 32'h44);
        in_ack = 1; in_data = 32'h1234_5678; tick(); in_ack = 0;
        tick();

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: no ack for TO cycles
        in_start = 1; tick(); in_start = 0;
        tick(); tick(); tick();
        chk("to_req_held", 32'(mem_if.memReadRequest), 32'h1);
        tick();
        chk("to_req_drop", 32'(mem_if.memReadRequest), 32'h0);
        chk("to_instr", instruction, 32'h13);
        chk("to_err", 32'(fetchError), 32'h1);
        chk("to_fetched", 32'(instructionFetched), 32'h1);
        tick();
        chk("to_err_end", 32'(fetchError), 32'h0);
`endif

        // Halt raised mid-request: transaction completes, then HALTED
        in_start = 1; tick(); in_start = 0;
        in_halt = 1; tick(); tick();
        in_ack = 1; in_data = 32'hCAFE_F00D; tick(); in_ack = 0;
        chk("h_instr", instruction, 32'hCAFE_F00D);
        chk("h_fetched", 32'(instructionFetched), 32'h1);
        tick();
        chk("h_pulse_end", 32'(instructionFetched), 32'h0);
        in_start = 1; in_pcw = 1; tick(); in_start = 0; in_pcw = 0;
        tick();
        chk("h_no_req", 32'(mem_if.memReadRequest), 32'h0);
        chk("h_no_upd", 32'(programCounterUpdated), 32'h0);

        // Reset in the middle of a request
        reset = 1; in_halt = 0; tick(); reset = 0;
        in_start = 1; tick(); in_start = 0;
        in_pcw = 1; in_bt = 1; in_tgt = 32'h80; tick(); in_pcw = 0;
        reset = 1; tick(); reset = 0;
        chk("r_req", 32'(mem_if.memReadRequest), 32'h0);
        chk("r_pc", programCounter, 32'h0);
        in_ack = 1; in_data = 32'hBAD0_BAD0; tick(); in_ack = 0;
        chk("r_no_fetch", 32'(instructionFetched), 32'h0);
        chk("r_instr", instruction, 32'h0);

        // Randomized traffic
        halt_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (reset) halt_lvl = 0;
            else if (!halt_lvl && $urandom_range(0, 299) == 0) halt_lvl = 1;
            in_halt  = halt_lvl;
            in_start = ($urandom_range(0, 3) == 0);
            in_pcw   = ($urandom_range(0, 4) == 0);
            in_bt    = $urandom_range(0, 1) == 1;
            in_tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            in_ack   = ($urandom_range(0, 2) == 0);
            in_data  = $urandom();
            tick();
        end

        @(posedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
